// File: rtl/adc_frame_pkg.sv
// adc_frame_pkg: shared constants and FSM state encoding for the ADC frame packer.
// The ST_CSUM state exists only when ADC_FRAME_CHECKSUM_EN is defined.
package adc_frame_pkg;

  localparam int          NUM_CH = 16;
  localparam int          CH_W   = $clog2(NUM_CH);
  localparam logic [15:0] HEADER = 16'hA5A5;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR,
    ST_SEQ,
    ST_CHAN
`ifdef ADC_FRAME_CHECKSUM_EN
    ,
    ST_CSUM
`endif
  } state_t;

endpackage

// File: rtl/adc_snapshot_buf.sv
// adc_snapshot_buf: single-entry snapshot of one ADC sample set plus its
// channel mask. A set arriving while the entry is occupied is discarded and
// counted; an entry released in the same cycle accepts the new set instead.
module adc_snapshot_buf
  import adc_frame_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     capture,
  input  logic                     rel,
  input  logic [NUM_CH*DATA_W-1:0] cap_data,
  input  logic [NUM_CH-1:0]        cap_mask,
  output logic                     full,
  output logic [NUM_CH*DATA_W-1:0] data,
  output logic [NUM_CH-1:0]        mask,
  output logic                     overflow,
  output logic [15:0]              drop_cnt
);

  logic take;
  logic drop;

  assign take = capture && (!full || rel);
  assign drop = capture && full && !rel;

  // Occupancy flag, sticky overflow and saturating drop counter
  always_ff @(posedge clk) begin
    if (rst) begin
      full     <= 1'b0;
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (take) begin
        full <= 1'b1;
      end else if (rel) begin
        full <= 1'b0;
      end
      if (drop) begin
        overflow <= 1'b1;
        if (drop_cnt != 16'hFFFF) begin
          drop_cnt <= drop_cnt + 1'b1;
        end
      end
    end
  end

  // Sample and mask latch; contents are meaningful only while full is set
  always_ff @(posedge clk) begin
    if (take) begin
      data <= cap_data;
      mask <= cap_mask;
    end
  end

endmodule

// File: rtl/adc_frame_packer.sv
// adc_frame_packer: turns each captured ADC sample set into a framed word
// stream (header, sequence number, enabled channels) on a valid/ready port.
// Build option: ADC_FRAME_CHECKSUM_EN appends a modulo-2^16 checksum word.
module adc_frame_packer
  import adc_frame_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic                     SAMPLE_VALID,
  input  logic [NUM_CH*DATA_W-1:0] SAMPLE_DATA,
  input  logic [NUM_CH-1:0]        CH_ENABLE,
  output logic [DATA_W-1:0]        OUT_DATA,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic                     OUT_SOF,
  output logic                     OUT_EOF,
  output logic                     OVERFLOW,
  output logic [15:0]              DROP_CNT
);

  localparam int SW = CH_W + 1;

  state_t                     state;
  logic [DATA_W-1:0]          seq_num;
  logic [CH_W-1:0]            cur_ch;
  logic                       snap_full;
  logic [NUM_CH*DATA_W-1:0]   snap_data;
  logic [NUM_CH-1:0]          snap_mask;
  logic                       acc;
  logic                       eof_acc;
  logic [SW-1:0]              srch_start;
  logic                       srch_found;
  logic [CH_W-1:0]            srch_idx;
  logic                       srch_last;
  logic [DATA_W-1:0]          ch_word;
`ifdef ADC_FRAME_CHECKSUM_EN
  logic [DATA_W-1:0]          csum;
  logic [DATA_W-1:0]          sum_nxt;

  assign sum_nxt = csum + OUT_DATA;
`endif

  assign acc     = OUT_VALID && OUT_READY;
  assign eof_acc = acc && OUT_EOF;
  assign ch_word = snap_data[srch_idx*DATA_W +: DATA_W];

  adc_snapshot_buf #(
    .DATA_W (DATA_W)
  ) u_snap (
    .clk      (CLK),
    .rst      (RESET),
    .capture  (SAMPLE_VALID),
    .rel      (eof_acc),
    .cap_data (SAMPLE_DATA),
    .cap_mask (CH_ENABLE),
    .full     (snap_full),
    .data     (snap_data),
    .mask     (snap_mask),
    .overflow (OVERFLOW),
    .drop_cnt (DROP_CNT)
  );

  // Lowest enabled channel at or above the search start, and whether it is the last one
  always_comb begin
    srch_start = (state == ST_SEQ) ? '0 : ({1'b0, cur_ch} + 1'b1);
    srch_found = 1'b0;
    srch_idx   = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (snap_mask[i] && (SW'(i) >= srch_start)) begin
        srch_found = 1'b1;
        srch_idx   = CH_W'(i);
      end
    end
    srch_last = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (snap_mask[i] && (SW'(i) > {1'b0, srch_idx})) begin
        srch_last = 1'b0;
      end
    end
  end

  // Frame sequencer; every stream output is registered and only advances on accept
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= ST_IDLE;
      OUT_VALID <= 1'b0;
      OUT_DATA  <= '0;
      OUT_SOF   <= 1'b0;
      OUT_EOF   <= 1'b0;
      seq_num   <= '0;
      cur_ch    <= '0;
    end else begin
      if (eof_acc) begin
        seq_num <= seq_num + 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (snap_full || SAMPLE_VALID) begin
            state     <= ST_HDR;
            OUT_VALID <= 1'b1;
            OUT_DATA  <= DATA_W'(HEADER);
            OUT_SOF   <= 1'b1;
            OUT_EOF   <= 1'b0;
          end
        end
        ST_HDR: begin
          if (acc) begin
            state    <= ST_SEQ;
            OUT_DATA <= seq_num;
            OUT_SOF  <= 1'b0;
`ifdef ADC_FRAME_CHECKSUM_EN
            OUT_EOF  <= 1'b0;
            csum     <= OUT_DATA;
`else
            OUT_EOF  <= (snap_mask == '0);
`endif
          end
        end
        ST_SEQ, ST_CHAN: begin
          if (acc) begin
`ifdef ADC_FRAME_CHECKSUM_EN
            csum <= sum_nxt;
`endif
            if (OUT_EOF) begin
              // Frame complete: chain straight into a set arriving this cycle
              if (SAMPLE_VALID) begin
                state     <= ST_HDR;
                OUT_DATA  <= DATA_W'(HEADER);
                OUT_SOF   <= 1'b1;
              end else begin
                state     <= ST_IDLE;
                OUT_VALID <= 1'b0;
                OUT_DATA  <= '0;
              end
              OUT_EOF <= 1'b0;
            end else if (srch_found) begin
              state    <= ST_CHAN;
              cur_ch   <= srch_idx;
              OUT_DATA <= ch_word;
`ifdef ADC_FRAME_CHECKSUM_EN
              OUT_EOF  <= 1'b0;
`else
              OUT_EOF  <= srch_last;
`endif
            end
`ifdef ADC_FRAME_CHECKSUM_EN
            else begin
              state    <= ST_CSUM;
              OUT_DATA <= sum_nxt;
              OUT_EOF  <= 1'b1;
            end
`endif
          end
        end
`ifdef ADC_FRAME_CHECKSUM_EN
        ST_CSUM: begin
          if (acc) begin
            if (SAMPLE_VALID) begin
              state     <= ST_HDR;
              OUT_DATA  <= DATA_W'(HEADER);
              OUT_SOF   <= 1'b1;
            end else begin
              state     <= ST_IDLE;
              OUT_VALID <= 1'b0;
              OUT_DATA  <= '0;
            end
            OUT_EOF <= 1'b0;
          end
        end
`endif
        default: begin
          state     <= ST_IDLE;
          OUT_VALID <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_packer.sv
// tb_adc_frame_packer: directed bench for adc_frame_packer.
// Honors ADC_FRAME_CHECKSUM_EN when building expected frames.
`timescale 1ns/1ps
module tb_adc_frame_packer;

  logic         CLK = 1'b0;
  logic         RESET;
  logic         SAMPLE_VALID;
  logic [255:0] SAMPLE_DATA;
  logic [15:0]  CH_ENABLE;
  logic [15:0]  OUT_DATA;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic         OUT_SOF;
  logic         OUT_EOF;
  logic         OVERFLOW;
  logic [15:0]  DROP_CNT;

  int          total = 0;
  int          bad   = 0;
  logic [15:0] chdata [16];
  logic [15:0] exp_w  [32];
  int          exp_len;
  logic [15:0] got_w  [32];
  bit          got_sof[32];
  bit          got_eof[32];
  int          nwords, first_cyc, last_cyc;
  bit          done;
  logic [15:0] exp_seq = 16'h0000;

  always #5 CLK = ~CLK;

  adc_frame_packer dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .SAMPLE_VALID (SAMPLE_VALID),
    .SAMPLE_DATA  (SAMPLE_DATA),
    .CH_ENABLE    (CH_ENABLE),
    .OUT_DATA     (OUT_DATA),
    .OUT_VALID    (OUT_VALID),
    .OUT_READY    (OUT_READY),
    .OUT_SOF      (OUT_SOF),
    .OUT_EOF      (OUT_EOF),
    .OVERFLOW     (OVERFLOW),
    .DROP_CNT     (DROP_CNT)
  );

  task automatic pack();
    for (int k = 0; k < 16; k++) SAMPLE_DATA[16*k +: 16] = chdata[k];
  endtask

  task automatic fill(input logic [15:0] base);
    for (int k = 0; k < 16; k++) chdata[k] = base + 16'(k);
  endtask

  // Expected frame: header, sequence, enabled channels ascending, optional checksum
  task automatic build_exp(input logic [15:0] mask, input logic [15:0] seq);
    logic [15:0] s;
    exp_w[0] = 16'hA5A5;
    exp_w[1] = seq;
    exp_len  = 2;
    for (int k = 0; k < 16; k++) begin
      if (mask[k]) begin
        exp_w[exp_len] = chdata[k];
        exp_len++;
      end
    end
`ifdef ADC_FRAME_CHECKSUM_EN
    s = 16'h0000;
    for (int i = 0; i < exp_len; i++) s = s + exp_w[i];
    exp_w[exp_len] = s;
    exp_len++;
`else
    s = 16'h0000;
`endif
  endtask

  // Record accepted words until EOF; optionally launch a new set on the EOF cycle
  task automatic collect(input bit chain);
    nwords = 0; done = 0; first_cyc = -1; last_cyc = -1;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge CLK);
      SAMPLE_VALID = 1'b0;
      if (OUT_VALID && OUT_READY && nwords < 32) begin
        if (first_cyc < 0) first_cyc = c;
        last_cyc        = c;
        got_w[nwords]   = OUT_DATA;
        got_sof[nwords] = OUT_SOF;
        got_eof[nwords] = OUT_EOF;
        nwords++;
        if (OUT_EOF) begin
          done = 1;
          if (chain) SAMPLE_VALID = 1'b1;
        end
      end
    end
    total++;
    if (!done) begin
      bad++;
      $display("FAIL collect_timeout: got no EOF, want EOF within 100 cycles");
    end
  endtask

  task automatic start_set(input logic [15:0] mask);
    @(negedge CLK);
    pack();
    CH_ENABLE    = mask;
    SAMPLE_VALID = 1'b1;
    OUT_READY    = 1'b1;
  endtask

  task automatic test_reset();
    RESET = 1'b1; SAMPLE_VALID = 1'b0; OUT_READY = 1'b0;
    SAMPLE_DATA = '0; CH_ENABLE = '0;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    @(negedge CLK);
    total++;
    if ({OUT_VALID, OUT_SOF, OUT_EOF, OVERFLOW} !== 4'b0000) begin
      bad++; $display("FAIL reset_flags: got %b want 0000", {OUT_VALID, OUT_SOF, OUT_EOF, OVERFLOW});
    end
    total++;
    if (OUT_DATA !== 16'h0000) begin
      bad++; $display("FAIL reset_data: got %h want 0000", OUT_DATA);
    end
    total++;
    if (DROP_CNT !== 16'h0000) begin
      bad++; $display("FAIL reset_drop: got %h want 0000", DROP_CNT);
    end
  endtask

  task automatic test_full_mask();
    fill(16'h1000);
    build_exp(16'hFFFF, exp_seq);
    start_set(16'hFFFF);
    collect(1'b0);
    total++;
    if (first_cyc !== 1) begin
      bad++; $display("FAIL full_latency: got %0d want 1", first_cyc);
    end
    total++;
    if (nwords !== exp_len) begin
      bad++; $display("FAIL full_len: got %0d want %0d", nwords, exp_len);
    end
    for (int i = 0; i < exp_len && i < nwords; i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_sof[i] !== (i == 0) || got_eof[i] !== (i == exp_len - 1)) begin
        bad++;
        $display("FAIL full_word%0d: got %h sof%0b eof%0b want %h sof%0b eof%0b",
                 i, got_w[i], got_sof[i], got_eof[i], exp_w[i], i == 0, i == exp_len - 1);
      end
    end
    exp_seq++;
  endtask

  task automatic test_sparse_mask();
    fill(16'h0000);
    chdata[0]  = 16'h0011;
    chdata[15] = 16'h00FF;
    build_exp(16'h8001, exp_seq);
    start_set(16'h8001);
    collect(1'b0);
    total++;
    if (nwords !== exp_len || (last_cyc - first_cyc + 1) !== nwords) begin
      bad++; $display("FAIL sparse_len: got %0d words over %0d cycles want %0d words no bubble",
                      nwords, last_cyc - first_cyc + 1, exp_len);
    end
    for (int i = 0; i < exp_len && i < nwords; i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_sof[i] !== (i == 0) || got_eof[i] !== (i == exp_len - 1)) begin
        bad++;
        $display("FAIL sparse_word%0d: got %h sof%0b eof%0b want %h", i, got_w[i], got_sof[i], got_eof[i], exp_w[i]);
      end
    end
    exp_seq++;
  endtask

  task automatic test_zero_mask();
    fill(16'h7700);
    build_exp(16'h0000, exp_seq);
    start_set(16'h0000);
    collect(1'b0);
    total++;
    if (nwords !== exp_len) begin
      bad++; $display("FAIL zero_len: got %0d want %0d", nwords, exp_len);
    end
    for (int i = 0; i < exp_len && i < nwords; i++) begin
      total++;
      if (got_w[i] !== exp_w[i] || got_eof[i] !== (i == exp_len - 1)) begin
        bad++; $display("FAIL zero_word%0d: got %h eof%0b want %h", i, got_w[i], got_eof[i], exp_w[i]);
      end
    end
    exp_seq++;
  endtask

  task automatic test_backpressure();
    logic [15:0] held;
    bit          stalled;
    fill(16'h2000);
    build_exp(16'hFFFF, exp_seq);
    start_set(16'hFFFF);
    nwords = 0; done = 0; stalled = 0; held = '0;
    for (int c = 1; c <= 100 && !done; c++) begin
      @(negedge CLK);
      if (stalled) begin
        total++;
        if (OUT_VALID !== 1'b1 || OUT_DATA !== held) begin
          bad++; $display("FAIL stall_hold: got v%0b %h want v1 %h", OUT_VALID, OUT_DATA, held);
        end
      end
      SAMPLE_VALID = (c == 5 || c == 7);
      if (SAMPLE_VALID) SAMPLE_DATA = {16{16'hDEAD}};
      OUT_READY = !(c >= 4 && c <= 8);
      if (OUT_VALID && OUT_READY && nwords < 32) begin
        got_w[nwords] = OUT_DATA;
        got_eof[nwords] = OUT_EOF;
        nwords++;
        if (OUT_EOF) done = 1;
      end
      stalled = OUT_VALID && !OUT_READY;
      held    = OUT_DATA;
    end
    SAMPLE_VALID = 1'b0;
    OUT_READY    = 1'b1;
    @(negedge CLK);
    total++;
    if (nwords !== exp_len) begin
      bad++; $display("FAIL bp_len: got %0d want %0d", nwords, exp_len);
    end
    for (int i = 0; i < exp_len && i < nwords; i++) begin
      total++;
      if (got_w[i] !== exp_w[i]) begin
        bad++; $display("FAIL bp_word%0d: got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
    total++;
    if (DROP_CNT !== 16'd2) begin
      bad++; $display("FAIL bp_drop_cnt: got %0d want 2", DROP_CNT);
    end
    total++;
    if (OVERFLOW !== 1'b1) begin
      bad++; $display("FAIL bp_overflow: got %0b want 1", OVERFLOW);
    end
    exp_seq++;
  endtask

  task automatic test_seq_wrap();
    @(negedge CLK);
    force dut.seq_num = 16'hFFFF;
    @(negedge CLK);
    release dut.seq_num;
    exp_seq = 16'hFFFF;
    fill(16'h4400);
    build_exp(16'h0000, exp_seq);
    start_set(16'h0000);
    collect(1'b1);
    total++;
    if (nwords !== exp_len || got_w[1] !== 16'hFFFF || got_w[exp_len-1] !== exp_w[exp_len-1]) begin
      bad++; $display("FAIL wrap_first: got len %0d seq %h want len %0d seq FFFF", nwords, got_w[1], exp_len);
    end
    exp_seq++;
    build_exp(16'h0000, exp_seq);
    collect(1'b0);
    total++;
    if (first_cyc !== 1) begin
      bad++; $display("FAIL b2b_gap: got header at cycle %0d want 1", first_cyc);
    end
    total++;
    if (nwords !== exp_len || got_w[0] !== 16'hA5A5 || got_w[1] !== 16'h0000 || got_w[exp_len-1] !== exp_w[exp_len-1]) begin
      bad++; $display("FAIL wrap_second: got len %0d %h %h want len %0d A5A5 0000", nwords, got_w[0], got_w[1], exp_len);
    end
    total++;
    if (DROP_CNT !== 16'd2) begin
      bad++; $display("FAIL b2b_no_drop: got %0d want 2", DROP_CNT);
    end
    exp_seq++;
  endtask

  task automatic test_mid_frame_reset();
    fill(16'h3000);
    start_set(16'hFFFF);
    repeat (5) begin
      @(negedge CLK);
      SAMPLE_VALID = 1'b0;
    end
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    total++;
    if (OUT_VALID !== 1'b0) begin
      bad++; $display("FAIL rst_valid: got %0b want 0", OUT_VALID);
    end
    total++;
    if (DROP_CNT !== 16'h0000 || OVERFLOW !== 1'b0) begin
      bad++; $display("FAIL rst_drop: got cnt %0d ovf %0b want 0 0", DROP_CNT, OVERFLOW);
    end
    exp_seq = 16'h0000;
    fill(16'h5000);
    build_exp(16'h0003, exp_seq);
    start_set(16'h0003);
    collect(1'b0);
    total++;
    if (nwords !== exp_len) begin
      bad++; $display("FAIL rst_frame_len: got %0d want %0d", nwords, exp_len);
    end
    for (int i = 0; i < exp_len && i < nwords; i++) begin
      total++;
      if (got_w[i] !== exp_w[i]) begin
        bad++; $display("FAIL rst_frame_word%0d: got %h want %h", i, got_w[i], exp_w[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_mask();
    test_sparse_mask();
    test_zero_mask();
    test_backpressure();
    test_seq_wrap();
    test_mid_frame_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
